// File: rtl/uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl
//
// Command sequencer sitting between the UART RX/TX pair and the register
// file / ALU. Byte-framed commands arrive from the receiver; the sequencer
// issues register-file writes and reads, loads ALU operands, triggers ALU
// operations and pushes response bytes into the TX FIFO.
//
// Commands (first byte, decoded in IDLE only):
//   0xAA addr data   : register write
//   0xBB addr        : register read, one response byte
//   0xCC A B fun     : write A->OPA_ADDR, B->OPB_ADDR, then ALU op
//   0xDD fun         : ALU op on current operands, two response bytes (LO, HI)
//
// Ports:
//   CLK, RST           : clock, asynchronous active-low reset
//   RX_P_DATA/RX_D_VLD : received byte and its one-cycle valid strobe
//   RX_ERR             : parity/stop error qualifying RX_D_VLD
//   RF_ADDR            : register-file address (held between strobes)
//   RF_WR_EN/RF_WR_DATA: register-file write strobe and data
//   RF_RD_EN           : register-file read strobe
//   RF_RD_DATA/RF_RD_VLD: read data and its valid
//   ALU_EN/ALU_FUN     : ALU operation strobe and function code
//   ALU_OUT/ALU_OUT_VLD: ALU result and its valid
//   CLK_GATE_EN        : ALU clock-gate enable, high while an op is pending
//   TX_DATA/TX_WR_EN   : byte and push strobe toward the TX FIFO
//   TX_FULL            : TX FIFO full, stalls the send states
//   BUSY               : high whenever the FSM is not in IDLE
//
// All outputs are registered: strobes appear the cycle after the event
// that triggers them.
// ---------------------------------------------------------------------------
module uart_cmd_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int OPA_ADDR   = 0,
  parameter int OPB_ADDR   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  RX_ERR,
  output logic [ADDR_WIDTH-1:0] RF_ADDR,
  output logic                  RF_WR_EN,
  output logic [7:0]            RF_WR_DATA,
  output logic                  RF_RD_EN,
  input  logic [7:0]            RF_RD_DATA,
  input  logic                  RF_RD_VLD,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  input  logic [15:0]           ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  output logic                  CLK_GATE_EN,
  output logic [7:0]            TX_DATA,
  output logic                  TX_WR_EN,
  input  logic                  TX_FULL,
  output logic                  BUSY
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    OPA      = 4'd5,
    OPB      = 4'd6,
    FUN      = 4'd7,
    ALU_WAIT = 4'd8,
    SEND_RD  = 4'd9,
    SEND_LO  = 4'd10,
    SEND_HI  = 4'd11
  } state_e;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam logic [ADDR_WIDTH-1:0] OPA_A = ADDR_WIDTH'(OPA_ADDR);
  localparam logic [ADDR_WIDTH-1:0] OPB_A = ADDR_WIDTH'(OPB_ADDR);

  // FSM state
  state_e state_q, state_d;

  // Internal latches: pending write address, read byte, ALU result
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [7:0]            rd_data_q;
  logic [15:0]           alu_res_q;

  // Output registers and their next-state values
  logic [ADDR_WIDTH-1:0] rf_addr_q,     rf_addr_d;
  logic                  rf_wr_en_q,    rf_wr_en_d;
  logic [7:0]            rf_wr_data_q,  rf_wr_data_d;
  logic                  rf_rd_en_q,    rf_rd_en_d;
  logic                  alu_en_q,      alu_en_d;
  logic [3:0]            alu_fun_q,     alu_fun_d;
  logic                  clk_gate_en_q, clk_gate_en_d;
  logic [7:0]            tx_data_q,     tx_data_d;
  logic                  tx_wr_en_q,    tx_wr_en_d;
  logic                  busy_q,        busy_d;

  // Qualified RX events: a good byte, or an errored byte that aborts
  logic byte_ok_s;
  logic byte_err_s;

  assign byte_ok_s  = RX_D_VLD & ~RX_ERR;
  assign byte_err_s = RX_D_VLD & RX_ERR;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an errored byte abandons any command in any state
  always_comb begin
    state_d = state_q;
    if (byte_err_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (byte_ok_s) begin
            case (RX_P_DATA)
              CMD_WR:      state_d = WR_ADDR;
              CMD_RD:      state_d = RD_ADDR;
              CMD_ALU_OP:  state_d = OPA;
              CMD_ALU_NOP: state_d = FUN;
              default:     state_d = IDLE;
            endcase
          end else begin
            state_d = IDLE;
          end
        end
        WR_ADDR: begin
          if (byte_ok_s) state_d = WR_DATA;
          else           state_d = WR_ADDR;
        end
        WR_DATA: begin
          if (byte_ok_s) state_d = IDLE;
          else           state_d = WR_DATA;
        end
        RD_ADDR: begin
          if (byte_ok_s) state_d = RD_WAIT;
          else           state_d = RD_ADDR;
        end
        RD_WAIT: begin
          if (RF_RD_VLD) state_d = SEND_RD;
          else           state_d = RD_WAIT;
        end
        OPA: begin
          if (byte_ok_s) state_d = OPB;
          else           state_d = OPA;
        end
        OPB: begin
          if (byte_ok_s) state_d = FUN;
          else           state_d = OPB;
        end
        FUN: begin
          if (byte_ok_s) state_d = ALU_WAIT;
          else           state_d = FUN;
        end
        ALU_WAIT: begin
          if (ALU_OUT_VLD) state_d = SEND_LO;
          else             state_d = ALU_WAIT;
        end
        SEND_RD: begin
          if (!TX_FULL) state_d = IDLE;
          else          state_d = SEND_RD;
        end
        SEND_LO: begin
          if (!TX_FULL) state_d = SEND_HI;
          else          state_d = SEND_LO;
        end
        SEND_HI: begin
          if (!TX_FULL) state_d = IDLE;
          else          state_d = SEND_HI;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output next-state logic; data-carrying outputs hold unless a strobe fires
  always_comb begin
    rf_addr_d     = rf_addr_q;
    rf_wr_en_d    = 1'b0;
    rf_wr_data_d  = rf_wr_data_q;
    rf_rd_en_d    = 1'b0;
    alu_en_d      = 1'b0;
    alu_fun_d     = alu_fun_q;
    clk_gate_en_d = 1'b0;
    tx_data_d     = tx_data_q;
    tx_wr_en_d    = 1'b0;
    busy_d        = (state_d != IDLE);
    if (byte_err_s) begin
      // Abort: no strobe, clock gate released, held values untouched
      clk_gate_en_d = 1'b0;
    end else begin
      case (state_q)
        WR_DATA: begin
          if (byte_ok_s) begin
            rf_wr_en_d   = 1'b1;
            rf_addr_d    = wr_addr_q;
            rf_wr_data_d = RX_P_DATA;
          end else begin
            rf_wr_en_d   = 1'b0;
          end
        end
        RD_ADDR: begin
          if (byte_ok_s) begin
            rf_rd_en_d = 1'b1;
            rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          end else begin
            rf_rd_en_d = 1'b0;
          end
        end
        OPA: begin
          if (byte_ok_s) begin
            rf_wr_en_d   = 1'b1;
            rf_addr_d    = OPA_A;
            rf_wr_data_d = RX_P_DATA;
          end else begin
            rf_wr_en_d   = 1'b0;
          end
        end
        OPB: begin
          if (byte_ok_s) begin
            rf_wr_en_d   = 1'b1;
            rf_addr_d    = OPB_A;
            rf_wr_data_d = RX_P_DATA;
          end else begin
            rf_wr_en_d   = 1'b0;
          end
        end
        FUN: begin
          if (byte_ok_s) begin
            alu_en_d      = 1'b1;
            alu_fun_d     = RX_P_DATA[3:0];
            clk_gate_en_d = 1'b1;
          end else begin
            alu_en_d      = 1'b0;
          end
        end
        ALU_WAIT: begin
          // Gate stays open until the result valid is observed
          clk_gate_en_d = ~ALU_OUT_VLD;
        end
        SEND_RD: begin
          if (!TX_FULL) begin
            tx_wr_en_d = 1'b1;
            tx_data_d  = rd_data_q;
          end else begin
            tx_wr_en_d = 1'b0;
          end
        end
        SEND_LO: begin
          if (!TX_FULL) begin
            tx_wr_en_d = 1'b1;
            tx_data_d  = alu_res_q[7:0];
          end else begin
            tx_wr_en_d = 1'b0;
          end
        end
        SEND_HI: begin
          if (!TX_FULL) begin
            tx_wr_en_d = 1'b1;
            tx_data_d  = alu_res_q[15:8];
          end else begin
            tx_wr_en_d = 1'b0;
          end
        end
        default: begin
          rf_wr_en_d = 1'b0;
        end
      endcase
    end
  end

  // Output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rf_addr_q     <= '0;
      rf_wr_en_q    <= 1'b0;
      rf_wr_data_q  <= 8'h00;
      rf_rd_en_q    <= 1'b0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= 4'h0;
      clk_gate_en_q <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_wr_en_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      rf_addr_q     <= rf_addr_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_wr_data_q  <= rf_wr_data_d;
      rf_rd_en_q    <= rf_rd_en_d;
      alu_en_q      <= alu_en_d;
      alu_fun_q     <= alu_fun_d;
      clk_gate_en_q <= clk_gate_en_d;
      tx_data_q     <= tx_data_d;
      tx_wr_en_q    <= tx_wr_en_d;
      busy_q        <= busy_d;
    end
  end

  // Command data latches: write address, read response, ALU result
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_addr_q <= '0;
      rd_data_q <= 8'h00;
      alu_res_q <= 16'h0000;
    end else if (byte_err_s) begin
      wr_addr_q <= wr_addr_q;
      rd_data_q <= rd_data_q;
      alu_res_q <= alu_res_q;
    end else begin
      if ((state_q == WR_ADDR) && byte_ok_s) begin
        wr_addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
      end else begin
        wr_addr_q <= wr_addr_q;
      end
      if ((state_q == RD_WAIT) && RF_RD_VLD) begin
        rd_data_q <= RF_RD_DATA;
      end else begin
        rd_data_q <= rd_data_q;
      end
      if ((state_q == ALU_WAIT) && ALU_OUT_VLD) begin
        alu_res_q <= ALU_OUT;
      end else begin
        alu_res_q <= alu_res_q;
      end
    end
  end

  assign RF_ADDR     = rf_addr_q;
  assign RF_WR_EN    = rf_wr_en_q;
  assign RF_WR_DATA  = rf_wr_data_q;
  assign RF_RD_EN    = rf_rd_en_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_GATE_EN = clk_gate_en_q;
  assign TX_DATA     = tx_data_q;
  assign TX_WR_EN    = tx_wr_en_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_ctrl: directed self-checking bench for uart_cmd_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are read at the
// same point, so a registered strobe caused by a byte is visible right after
// the tick that delivered the byte.
// ---------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

  logic        CLK;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic        RX_ERR;
  logic [3:0]  RF_ADDR;
  logic        RF_WR_EN;
  logic [7:0]  RF_WR_DATA;
  logic        RF_RD_EN;
  logic [7:0]  RF_RD_DATA;
  logic        RF_RD_VLD;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        CLK_GATE_EN;
  logic [7:0]  TX_DATA;
  logic        TX_WR_EN;
  logic        TX_FULL;
  logic        BUSY;

  int checks   = 0;
  int failures = 0;

  // Pulse counters sampled on the falling edge, away from output updates
  int tx_cnt    = 0;
  int rf_wr_cnt = 0;
  int base_tx;
  int base_wr;

  uart_cmd_ctrl #(.ADDR_WIDTH(4), .OPA_ADDR(0), .OPB_ADDR(1)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RX_ERR(RX_ERR),
    .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_WR_DATA(RF_WR_DATA),
    .RF_RD_EN(RF_RD_EN), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT),
    .ALU_OUT_VLD(ALU_OUT_VLD), .CLK_GATE_EN(CLK_GATE_EN),
    .TX_DATA(TX_DATA), .TX_WR_EN(TX_WR_EN), .TX_FULL(TX_FULL), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (TX_WR_EN) tx_cnt <= tx_cnt + 1;
    if (RF_WR_EN) rf_wr_cnt <= rf_wr_cnt + 1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    RX_ERR    = err;
    tick();
    RX_D_VLD  = 1'b0;
    RX_ERR    = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_EN, ALU_FUN,
                CLK_GATE_EN, TX_DATA, TX_WR_EN, BUSY});
  endfunction

  initial begin
    RST = 1'b1; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0; RX_ERR = 1'b0;
    RF_RD_DATA = 8'h00; RF_RD_VLD = 1'b0; ALU_OUT = 16'h0000;
    ALU_OUT_VLD = 1'b0; TX_FULL = 1'b0;
    #3 RST = 1'b0;
    tick(); tick();
    chk("reset_outputs", all_outs(), 32'h0);
    RST = 1'b1;
    tick();
    chk("idle_outputs", all_outs(), 32'h0);

    // Register write AA,05,3C
    base_tx = tx_cnt; base_wr = rf_wr_cnt;
    send_byte(8'hAA, 1'b0);
    chk("wr_busy", 32'(BUSY), 32'h1);
    send_byte(8'h05, 1'b0);
    chk("wr_no_early_strobe", 32'(RF_WR_EN), 32'h0);
    send_byte(8'h3C, 1'b0);
    chk("wr_en", 32'(RF_WR_EN), 32'h1);
    chk("wr_addr", 32'(RF_ADDR), 32'h5);
    chk("wr_data", 32'(RF_WR_DATA), 32'h3C);
    chk("wr_busy_done", 32'(BUSY), 32'h0);
    tick();
    chk("wr_en_pulse", 32'(RF_WR_EN), 32'h0);
    chk("wr_addr_hold", 32'(RF_ADDR), 32'h5);
    chk("wr_count", 32'(rf_wr_cnt - base_wr), 32'd1);
    chk("wr_no_tx", 32'(tx_cnt - base_tx), 32'd0);

    // Register read BB,07 -> 0x9E
    base_tx = tx_cnt;
    send_byte(8'hBB, 1'b0);
    send_byte(8'h07, 1'b0);
    chk("rd_en", 32'(RF_RD_EN), 32'h1);
    chk("rd_addr", 32'(RF_ADDR), 32'h7);
    tick();
    chk("rd_en_pulse", 32'(RF_RD_EN), 32'h0);
    chk("rd_wait_busy", 32'(BUSY), 32'h1);
    tick(); tick();
    RF_RD_DATA = 8'h9E; RF_RD_VLD = 1'b1;
    tick();
    RF_RD_VLD = 1'b0; RF_RD_DATA = 8'h00;
    chk("rd_no_early_tx", 32'(TX_WR_EN), 32'h0);
    tick();
    chk("rd_tx_en", 32'(TX_WR_EN), 32'h1);
    chk("rd_tx_data", 32'(TX_DATA), 32'h9E);
    chk("rd_busy_done", 32'(BUSY), 32'h0);
    tick();
    chk("rd_tx_count", 32'(tx_cnt - base_tx), 32'd1);

    // ALU with operands CC,12,34,02 -> 0x0468
    base_tx = tx_cnt;
    send_byte(8'hCC, 1'b0);
    send_byte(8'h12, 1'b0);
    chk("opa_wr_en", 32'(RF_WR_EN), 32'h1);
    chk("opa_addr", 32'(RF_ADDR), 32'h0);
    chk("opa_data", 32'(RF_WR_DATA), 32'h12);
    send_byte(8'h34, 1'b0);
    chk("opb_wr_en", 32'(RF_WR_EN), 32'h1);
    chk("opb_addr", 32'(RF_ADDR), 32'h1);
    chk("opb_data", 32'(RF_WR_DATA), 32'h34);
    send_byte(8'h02, 1'b0);
    chk("alu_en", 32'(ALU_EN), 32'h1);
    chk("alu_fun", 32'(ALU_FUN), 32'h2);
    chk("alu_cg_on", 32'(CLK_GATE_EN), 32'h1);
    chk("alu_no_wr", 32'(RF_WR_EN), 32'h0);
    tick();
    chk("alu_en_pulse", 32'(ALU_EN), 32'h0);
    chk("alu_cg_hold", 32'(CLK_GATE_EN), 32'h1);
    tick();
    ALU_OUT = 16'h0468; ALU_OUT_VLD = 1'b1;
    tick();
    ALU_OUT_VLD = 1'b0; ALU_OUT = 16'h0000;
    chk("alu_cg_off", 32'(CLK_GATE_EN), 32'h0);
    tick();
    chk("alu_tx_lo_en", 32'(TX_WR_EN), 32'h1);
    chk("alu_tx_lo", 32'(TX_DATA), 32'h68);
    tick();
    chk("alu_tx_hi_en", 32'(TX_WR_EN), 32'h1);
    chk("alu_tx_hi", 32'(TX_DATA), 32'h04);
    chk("alu_busy_done", 32'(BUSY), 32'h0);
    tick();
    chk("alu_tx_count", 32'(tx_cnt - base_tx), 32'd2);

    // ALU without operands DD,01, FIFO full for 10 cycles in SEND_LO
    base_tx = tx_cnt;
    send_byte(8'hDD, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("nop_alu_en", 32'(ALU_EN), 32'h1);
    chk("nop_alu_fun", 32'(ALU_FUN), 32'h1);
    TX_FULL = 1'b1;
    ALU_OUT = 16'hABCD; ALU_OUT_VLD = 1'b1;
    tick();
    ALU_OUT_VLD = 1'b0; ALU_OUT = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("full_no_push", 32'(TX_WR_EN), 32'h0);
    end
    chk("full_busy", 32'(BUSY), 32'h1);
    TX_FULL = 1'b0;
    tick();
    chk("full_lo_en", 32'(TX_WR_EN), 32'h1);
    chk("full_lo", 32'(TX_DATA), 32'hCD);
    tick();
    chk("full_hi_en", 32'(TX_WR_EN), 32'h1);
    chk("full_hi", 32'(TX_DATA), 32'hAB);
    tick();
    chk("full_done", 32'(TX_WR_EN), 32'h0);
    chk("full_tx_count", 32'(tx_cnt - base_tx), 32'd2);

    // Errored byte aborts a write; next write completes
    base_wr = rf_wr_cnt;
    send_byte(8'hAA, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h77, 1'b1);
    chk("err_busy", 32'(BUSY), 32'h0);
    chk("err_no_wr", 32'(RF_WR_EN), 32'h0);
    tick();
    chk("err_wr_count", 32'(rf_wr_cnt - base_wr), 32'd0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h06, 1'b0);
    send_byte(8'h11, 1'b0);
    chk("err_next_wr_en", 32'(RF_WR_EN), 32'h1);
    chk("err_next_addr", 32'(RF_ADDR), 32'h6);
    chk("err_next_data", 32'(RF_WR_DATA), 32'h11);
    // Stray byte in IDLE
    send_byte(8'h55, 1'b0);
    chk("stray_busy", 32'(BUSY), 32'h0);
    send_byte(8'h05, 1'b0);
    chk("stray_still_idle", 32'(BUSY), 32'h0);
    chk("stray_no_wr", 32'(RF_WR_EN), 32'h0);

    // Reset during ALU_WAIT
    base_tx = tx_cnt;
    send_byte(8'hDD, 1'b0);
    send_byte(8'h03, 1'b0);
    tick();
    chk("rst_pre_cg", 32'(CLK_GATE_EN), 32'h1);
    chk("rst_pre_busy", 32'(BUSY), 32'h1);
    RST = 1'b0;
    #1;
    chk("rst_mid_outputs", all_outs(), 32'h0);
    tick();
    RST = 1'b1;
    ALU_OUT = 16'h1234; ALU_OUT_VLD = 1'b1;
    tick();
    ALU_OUT_VLD = 1'b0;
    tick(); tick(); tick();
    chk("rst_late_vld_no_tx", 32'(tx_cnt - base_tx), 32'd0);
    chk("rst_late_busy", 32'(BUSY), 32'h0);
    chk("rst_late_cg", 32'(CLK_GATE_EN), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against an unexpected stall of the sequence
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
